// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding, per-bit phase encoding and bus mode.
// Reused by the slave side so both ends agree on phase numbering.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETUP,
    ST_TRANSFER,
    ST_HOLD
  } spi_state_e;

  typedef logic [1:0] spi_phase_t;

  localparam spi_phase_t PH_DRIVE  = 2'd0;
  localparam spi_phase_t PH_RISE   = 2'd1;
  localparam spi_phase_t PH_SAMPLE = 2'd2;
  localparam spi_phase_t PH_FALL   = 2'd3;

  // Mode number is {CPOL, CPHA}.
  localparam int SPI_MODE = 0;

  function automatic logic sclk_idle_level(input int mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/sclk_pulse_gen.sv
// Free-running divider: one-cycle SCLK_PULSE every CLK_DIV cycles of CTRL_CLK.
// Runs continuously, including while the attached peripheral is idle.
module sclk_pulse_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CTRL_CLK,
  input  logic RST,
  output logic SCLK_PULSE
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CTRL_CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign SCLK_PULSE = (cnt_q == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one word per START, MSB first, DONE strobe with received word.
// Pin updates only on SCLK_PULSE cycles; START accepted only when idle and not in the DONE cycle.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  CTRL_CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  SCLK_PULSE,
  output logic                  CS,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNTW    = $clog2(CNT_MAX + 1);
  localparam int BITW    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNTW-1:0] SETUP_LAST = CNTW'(CS_SETUP - 1);
  localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'(CS_HOLD - 1);
  localparam logic [BITW-1:0] LAST_BIT   = BITW'(DATA_WIDTH - 1);
  localparam logic            SCLK_IDLE  = sclk_idle_level(SPI_MODE);

  spi_state_e            state_q;
  logic [CNTW-1:0]       cnt_q;
  spi_phase_t            phase_q;
  logic [BITW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  cs_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  busy_q;
  logic                  done_q;

  sclk_pulse_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pulse (
    .CTRL_CLK  (CTRL_CLK),
    .RST       (RST),
    .SCLK_PULSE(SCLK_PULSE)
  );

  always_ff @(posedge CTRL_CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_q    <= PH_DRIVE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Acceptance on a pulse cycle takes precedence; ARM then waits for the following pulse.
      if (state_q == ST_IDLE) begin
        if (START && !busy_q && !done_q) begin
          tx_shift_q <= TX_DATA;
          busy_q     <= 1'b1;
          state_q    <= ST_ARM;
        end
      end else if (SCLK_PULSE) begin
        case (state_q)
          ST_ARM: begin
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_SETUP;
          end
          ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
              phase_q   <= PH_DRIVE;
              bit_cnt_q <= '0;
              state_q   <= ST_TRANSFER;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
          ST_TRANSFER: begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              PH_DRIVE:  mosi_q <= tx_shift_q[DATA_WIDTH-1];
              PH_RISE:   sclk_q <= ~SCLK_IDLE;
              PH_SAMPLE: rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], MISO};
              PH_FALL: begin
                sclk_q     <= SCLK_IDLE;
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_q  <= bit_cnt_q + BITW'(1);
                if (bit_cnt_q == LAST_BIT) begin
                  cnt_q   <= '0;
                  state_q <= ST_HOLD;
                end
              end
            endcase
          end
          ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              cs_q      <= 1'b1;
              mosi_q    <= 1'b0;
              rx_data_q <= rx_shift_q;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign RX_DATA = rx_data_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign CS      = cs_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=4/DW=8 and CLK_DIV=2/DW=16) against a
// transaction-timing model plus pin-invariant checks and directed literal expectations.
module tb_spi_master_ctrl;

  localparam int SETUP_P = 2;
  localparam int HOLD_P  = 2;

  logic        clk;
  logic        rst;
  logic        start    [2];
  logic [15:0] txd      [2];
  logic        busy     [2];
  logic        done     [2];
  logic        pulse    [2];
  logic        cs       [2];
  logic        sclk     [2];
  logic        mosi     [2];
  logic        miso     [2];
  int          miso_mode[2];
  logic [7:0]  rx0;
  logic [15:0] rx1;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: loopback, 1: held high, 2: held low
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      miso[i] = (miso_mode[i] == 0) ? mosi[i] : (miso_mode[i] == 1);
    end
  end

  spi_master_ctrl u_dut0 (
    .CTRL_CLK  (clk),
    .RST       (rst),
    .START     (start[0]),
    .TX_DATA   (txd[0][7:0]),
    .RX_DATA   (rx0),
    .BUSY      (busy[0]),
    .DONE      (done[0]),
    .SCLK_PULSE(pulse[0]),
    .CS        (cs[0]),
    .SCLK      (sclk[0]),
    .MOSI      (mosi[0]),
    .MISO      (miso[0])
  );

  spi_master_ctrl #(
    .CLK_DIV   (2),
    .DATA_WIDTH(16)
  ) u_dut1 (
    .CTRL_CLK  (clk),
    .RST       (rst),
    .START     (start[1]),
    .TX_DATA   (txd[1]),
    .RX_DATA   (rx1),
    .BUSY      (busy[1]),
    .DONE      (done[1]),
    .SCLK_PULSE(pulse[1]),
    .CS        (cs[1]),
    .SCLK      (sclk[1]),
    .MOSI      (mosi[1]),
    .MISO      (miso[1])
  );

  function automatic int cdiv(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int dwid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic logic [15:0] dmask(input int i);
    return (i == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] get_rx(input int i);
    return (i == 0) ? {8'h00, rx0} : rx1;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=0x%0h want=0x%0h t=%0t", name, idx, act, exp, $time);
    end
  endtask

  // Model state: cycle index n counts from reset release (cycle 0 = first cycle out of reset).
  int          n;
  bit          active   [2];
  int          acc      [2];
  int          arm      [2];
  int          dn       [2];
  int          last_done[2];
  logic [15:0] m_tx     [2];
  logic [15:0] m_rxexp  [2];
  logic [15:0] m_rx     [2];
  logic [15:0] word     [2];
  int          rises    [2];
  logic        psclk    [2];
  logic        pmosi    [2];
  logic        pcs      [2];
  int          cs_fall_n[2];
  int          cs_rise_n[2];
  int          last_gap [2];
  int          done_n   [2];
  int          done_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    int   cd, dw, p;
    logic e_pulse, e_busy, e_done, e_cs;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 2; i++) begin
        active[i]    = 1'b0;
        last_done[i] = -10;
        m_rx[i]      = '0;
        rises[i]     = 0;
        word[i]      = '0;
        psclk[i]     = 1'b0;
        pmosi[i]     = 1'b0;
        pcs[i]       = 1'b1;
        cs_rise_n[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cd      = cdiv(i);
        dw      = dwid(i);
        e_pulse = ((n % cd) == cd - 1);
        e_busy  = active[i] && (n > acc[i]) && (n < dn[i]);
        e_done  = active[i] && (n == dn[i]);
        e_cs    = !(active[i] && (n > arm[i]) && (n < dn[i]));
        if (e_done) m_rx[i] = m_rxexp[i];

        chk("sclk_pulse", i, pulse[i], e_pulse);
        chk("busy", i, busy[i], e_busy);
        chk("done", i, done[i], e_done);
        chk("cs", i, cs[i], e_cs);
        chk("rx_data", i, get_rx(i), m_rx[i]);
        chk("sclk_while_cs_high", i, cs[i] & sclk[i], 0);
        chk("mosi_while_cs_high", i, cs[i] & mosi[i], 0);
        if (mosi[i] !== pmosi[i]) chk("mosi_change_sclk_low", i, sclk[i] | psclk[i], 0);

        if (!psclk[i] && sclk[i]) begin
          rises[i]++;
          word[i] = {word[i][14:0], mosi[i]};
        end
        if (cs[i] && !pcs[i]) cs_rise_n[i] = n;
        if (!cs[i] && pcs[i]) begin
          cs_fall_n[i] = n;
          last_gap[i]  = n - cs_rise_n[i];
        end
        if (done[i]) begin
          done_cnt[i]++;
          done_n[i] = n;
        end

        if (e_done) begin
          chk("sclk_rises", i, rises[i], dw);
          chk("mosi_word", i, word[i] & dmask(i), m_tx[i]);
          active[i]    = 1'b0;
          last_done[i] = n;
        end

        if (!active[i] && start[i] && (n != last_done[i])) begin
          active[i] = 1'b1;
          acc[i]    = n;
          p = n + 1;
          while ((p % cd) != cd - 1) p++;
          arm[i] = p;
          dn[i]  = p + 1 + cd * (SETUP_P + 4 * dw + HOLD_P);
          m_tx[i] = txd[i] & dmask(i);
          case (miso_mode[i])
            0:       m_rxexp[i] = m_tx[i];
            1:       m_rxexp[i] = dmask(i);
            default: m_rxexp[i] = '0;
          endcase
          rises[i] = 0;
          word[i]  = '0;
        end

        psclk[i] = sclk[i];
        pmosi[i] = mosi[i];
        pcs[i]   = cs[i];
      end
      n++;
    end
  end

  task automatic send(input int i, input logic [15:0] data);
    @(posedge clk);
    #1;
    txd[i]   = data;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    int k;
    k = 0;
    while (done[i] !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_bound", i, done[i], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i]     = 1'b0;
      txd[i]       = '0;
      miso_mode[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", i, cs[i], 1);
      chk("rst_sclk", i, sclk[i], 0);
      chk("rst_mosi", i, mosi[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_rx", i, get_rx(i), 0);
    end

    // Loopback 0xA5
    miso_mode[0] = 0;
    send(0, 16'h00A5);
    wait_done(0, 400);
    @(posedge clk); #1;
    chk("latency_a5", 0, done_n[0] - cs_fall_n[0], 144);
    chk("rx_a5", 0, get_rx(0), 16'h00A5);

    // MISO held high then low
    miso_mode[0] = 1;
    send(0, 16'h0000);
    wait_done(0, 400);
    @(posedge clk); #1;
    chk("rx_miso1", 0, get_rx(0), 16'h00FF);
    miso_mode[0] = 2;
    send(0, 16'h00FF);
    wait_done(0, 400);
    @(posedge clk); #1;
    chk("rx_miso0", 0, get_rx(0), 16'h0000);

    // START mid-transfer is ignored
    miso_mode[0] = 0;
    c0 = done_cnt[0];
    send(0, 16'h00C3);
    repeat (70) @(posedge clk);
    send(0, 16'h003C);
    wait_done(0, 400);
    repeat (200) @(posedge clk);
    #1;
    chk("single_done", 0, done_cnt[0] - c0, 1);
    chk("rx_first_word", 0, get_rx(0), 16'h00C3);

    // Reset during bit 4
    send(0, 16'h0081);
    k = 0;
    while (rises[0] < 5 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reached_bit4", 0, rises[0], 5);
    c0 = done_cnt[0];
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs", 0, cs[0], 1);
    chk("abort_sclk", 0, sclk[0], 0);
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_done", 0, done[0], 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rx", 0, get_rx(0), 0);
    rst = 1'b0;
    send(0, 16'h005A);
    wait_done(0, 400);
    @(posedge clk); #1;
    chk("done_after_abort", 0, done_cnt[0] - c0, 1);
    chk("rx_5a", 0, get_rx(0), 16'h005A);

    // Wide instance, fast divider
    miso_mode[1] = 0;
    send(1, 16'hBEEF);
    wait_done(1, 400);
    @(posedge clk); #1;
    chk("latency_beef", 1, done_n[1] - cs_fall_n[1], 136);
    chk("rx_beef", 1, get_rx(1), 16'hBEEF);

    // Back-to-back: START in the cycle right after DONE
    send(0, 16'h0012);
    wait_done(0, 400);
    @(posedge clk);
    #1;
    txd[0]   = 16'h0034;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("b2b_accepted", 0, busy[0], 1);
    wait_done(0, 400);
    @(posedge clk); #1;
    chk("rx_b2b", 0, get_rx(0), 16'h0034);
    chk("cs_gap_min", 0, (last_gap[0] >= 4), 1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Mode-0 SPI master. Sits directly upstream of the SPI slave and drives its CS, SCLK, SDI and SCLK_PULSE inputs; samples the slave's SDO.
- Accepts one DATA_WIDTH-bit word per START handshake from the control logic, shifts it out MSB first and returns the received word with a DONE strobe.
- Generates the shared SCLK_PULSE strobe that the slave uses as its timing domain.

Parameters:
- CLK_DIV, 4: CTRL_CLK cycles per SCLK_PULSE. Minimum 2.
- DATA_WIDTH, 8: bits per transaction.
- CS_SETUP, 2: SCLK_PULSEs between CS falling and the first bit. Minimum 1.
- CS_HOLD, 2: SCLK_PULSEs after the last bit before CS rises. Minimum 1.

Ports:
- CTRL_CLK  in  1  single system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request a transaction; sampled every CTRL_CLK cycle.
- TX_DATA  in  DATA_WIDTH  word to send; captured when START is accepted.
- RX_DATA  out  DATA_WIDTH  last received word; stable between DONE strobes.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle strobe; transaction complete, RX_DATA valid.
- SCLK_PULSE  out  1  one-cycle strobe every CLK_DIV cycles; free-running, to slave.
- CS  out  1  active-low chip select to slave.
- SCLK  out  1  SPI clock, idles low.
- MOSI  out  1  data to slave SDI.
- MISO  in  1  data from slave SDO.

Behaviour:
- Reset (asynchronous, immediate):
  - CS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0.
  - Divider counter=0; state=IDLE.
  - Reset asserted mid-transaction aborts with no DONE and leaves RX_DATA=0.
- Divider:
  - Counter runs 0..CLK_DIV-1 continuously, including in IDLE, so the slave can detect CS.
  - SCLK_PULSE=1 when counter==CLK_DIV-1.
  - All state and pin updates below happen only on cycles where SCLK_PULSE=1, except START acceptance and DONE.
- START acceptance:
  - START is accepted only in IDLE with BUSY=0. On acceptance, TX_DATA is latched into the tx shift register and BUSY=1 on the next cycle.
  - START while BUSY=1 is ignored; no queueing.
  - State goes to ARM.
  - START coinciding with an SCLK_PULSE cycle counts as accepted before that pulse; ARM completes on the next pulse.
- FSM states: IDLE -> ARM -> SETUP -> TRANSFER -> HOLD -> IDLE.
  - ARM: on the first pulse, CS<=0, setup counter=0, go to SETUP.
  - SETUP: counter increments each pulse. When counter==CS_SETUP-1, go to TRANSFER with phase=0 and bit_cnt=0.
  - TRANSFER: 2-bit phase, 4 pulses per bit.
    - ph0: MOSI<=tx_shift[MSB].
    - ph1: SCLK<=1.
    - ph2: rx_shift<={rx_shift, MISO}.
    - ph3: SCLK<=0, tx_shift<<=1, bit_cnt++. If bit_cnt==DATA_WIDTH-1, go to HOLD with counter=0.
  - HOLD: counter increments each pulse. When counter==CS_HOLD-1:
    - CS<=1, MOSI<=0, RX_DATA<=rx_shift.
    - DONE=1 for that single cycle, BUSY<=0, go to IDLE.
- Latency: from the first pulse after acceptance (ARM pulse) to DONE is CS_SETUP+4*DATA_WIDTH+CS_HOLD pulses. With defaults this is 36 pulses = 144 CTRL_CLK cycles.
- Pin invariants:
  - Exactly DATA_WIDTH SCLK rising edges per transaction.
  - SCLK never toggles while CS=1.
  - MOSI changes only while SCLK=0.
- A new START is accepted on the cycle after DONE at the earliest. CS then stays high for at least one full pulse period, guaranteed by ARM.
- Bit order: MSB first on both MOSI and RX_DATA.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE, ARM, SETUP, TRANSFER, HOLD).
  - Phase constants PH_DRIVE=0, PH_RISE=1, PH_SAMPLE=2, PH_FALL=3.
  - SPI mode constant (0). These are reused by the slave side.
- One sub-module: sclk_pulse_gen (parameter CLK_DIV; ports CTRL_CLK, RST, SCLK_PULSE). It is reusable for other SPI peripherals.

Test Plan:
- Loopback (MISO tied to MOSI), TX_DATA=0xA5, START one cycle:
  - DONE after 144 cycles measured from the ARM pulse; RX_DATA=0xA5.
  - Exactly 8 SCLK rising edges; CS low throughout.
- MISO held 1, TX_DATA=0x00: RX_DATA=0xFF, MOSI never 1. Then MISO held 0: next RX_DATA=0x00.
- START asserted again at transfer midpoint with TX_DATA=0x3C: ignored, single DONE, RX_DATA reflects the first word; BUSY never drops early.
- RST pulsed during TRANSFER bit 4: CS=1, SCLK=0, BUSY=0 immediately, no DONE. A following transaction with 0x5A completes correctly.
- SCLK_PULSE period = CLK_DIV cycles in IDLE and during transfer. Repeat with CLK_DIV=2 and DATA_WIDTH=16, loopback 0xBEEF -> RX_DATA=0xBEEF.
- Back-to-back: START on the cycle after DONE: accepted; CS high for at least CLK_DIV cycles between transactions.
